fifo_stream_out: RTL and testbench
==================================

# fifo_stream_out

Pop-side adapter for the synchronous FIFO: drains its first-word-fall-through read port into a registered valid/ready stream for the downstream datapath. Holds up to two words in a registered output buffer, so the FIFO pop is never combinationally dependent on downstream ready. Frames the stream into fixed-length packets with a last-beat flag, and supports a synchronous flush that runs in lockstep with the FIFO flush.

## Interface

Parameters:
- WIDTH, 16, data width; must equal the FIFO WIDTH.
- PKT_LEN, 4, beats per packet; must be >= 1.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  synchronous clear; tied to the same source as the FIFO i_flush.
- i_fifo_rdata  in  WIDTH  FIFO head word, valid while i_fifo_not_empty is high.
- i_fifo_not_empty  in  1  FIFO holds at least one word.
- o_fifo_pop  out  1  pop strobe to the FIFO; consumes i_fifo_rdata this cycle.
- o_valid  out  1  o_data is valid.
- o_data  out  WIDTH  stream data, registered.
- o_last  out  1  final beat of the current packet; qualified by o_valid.
- i_ready  in  1  downstream accepts the beat when o_valid && i_ready.

## Operation

- Buffer: two registered entries, e0 (head, drives o_data) and e1 (skid), plus count in {0,1,2}. o_valid = (count != 0).
- pop = i_rst_n && !i_flush && i_fifo_not_empty && (count != 2). o_fifo_pop = pop. Depends only on registered count and the FIFO flag.
- acc = o_valid && i_ready.
- Next count = count + pop - acc.
- Data movement (no reset or flush):
  - count 0, pop: e0 <= rdata.
  - count 1, pop, !acc: e1 <= rdata.
  - count 1, pop, acc: e0 <= rdata.
  - count 2, acc: e0 <= e1.
  - All other cases: entries hold.
- Order preserved: beats leave in FIFO pop order, with no loss or duplication.
- Beat counter beat, width max(1, clog2(PKT_LEN)):
  - Increments on acc.
  - Wraps to 0 on acc when beat == PKT_LEN-1.
- o_last = o_valid && (beat == PKT_LEN-1). When PKT_LEN = 1, o_last = o_valid.
- Flush (i_flush high, i_rst_n high), at the clock edge:
  - count <= 0, beat <= 0, e0 and e1 <= 0.
  - No pop in that cycle.
  - A beat presented during the flush cycle counts as dropped, even if i_ready is high.
- Reset (i_rst_n low) behaves the same as flush and takes priority over it. Reset asserted mid-packet discards buffered words and restarts framing at beat 0.
- Protocol: once o_valid is asserted, o_data and o_last hold stable until acc. An unsupported PKT_LEN < 1 is a synthesis error, not handled.

## Timing

- Values after reset:
  - o_valid 0, o_data 0, o_last 0.
  - o_fifo_pop 0 while i_rst_n is low.
  - Internal count 0, beat 0.
- Latency: a word popped on edge N appears on o_valid/o_data after edge N, one cycle later.
- Throughput: one beat per cycle with i_ready held high and FIFO non-empty; count settles at 1.
- Downstream stall: at most two further pops after i_ready drops; then o_fifo_pop stays low until acc.
- FIFO empty: o_fifo_pop stays low. o_valid drops on the cycle after the last buffered beat is accepted.
- Combinational paths:
  - None from i_ready to o_fifo_pop.
  - i_fifo_not_empty and i_flush to o_fifo_pop only.

## Structure

- Shared package fifo_pkg: clog2 function (used to size beat and the FIFO address width), so the FIFO and this block compute widths identically.
- Sub-module skid_buf2 (WIDTH): the two-entry buffer and count, with ports push/din/full_n and valid/dout/ready/clear.
- Top level adds pop generation, beat counter and o_last.

## Test plan

- Reset with the FIFO preloaded with 0x0001..0x0008, i_ready high, PKT_LEN=4:
  - o_data 0x0001..0x0008 on consecutive cycles starting 1 cycle after reset release.
  - o_last on 0x0004 and 0x0008.
  - o_valid drops 1 cycle after 0x0008 is accepted.
- Backpressure: i_ready low for 5 cycles mid-stream, with the FIFO full:
  - Exactly 2 pops after the stall begins, then o_fifo_pop stays 0.
  - o_data stays stable; resume yields the contiguous sequence with no gaps or repeats.
- Random i_ready (50%) with random FIFO fill, 1000 words:
  - Scoreboard matches order.
  - o_last on every 4th accepted beat.
  - Valid/data never change while stalled.
- Flush at beat 2 of a packet with count=2:
  - Next cycle o_valid=0 and no pop occurred in the flush cycle.
  - After refill, the first beat has beat index 0 (o_last on the 4th beat).
- Reset asserted for 1 cycle mid-packet with i_ready high:
  - o_fifo_pop=0 during reset.
  - All outputs 0 on the next cycle.
  - Framing restarts at beat 0.
- PKT_LEN=1 build: o_last equals o_valid on every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width helpers and buffer fill encoding for the synchronous FIFO and
// its stream-side adapters, so every block sizes counters identically.
package fifo_pkg;

  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_ONE   = 2'd1,
    FILL_TWO   = 2'd2
  } fill_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // A single-beat packet still needs a one-bit beat counter.
  function automatic int beat_width(input int pkt_len);
    int w;
    w = clog2(pkt_len);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_stream_out_skid_buf2.sv
// Two-entry registered output buffer: e0 is the presented head, e1 catches the
// word that was already in flight when downstream stalled.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full_n,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  input  logic             ready
);

  fill_e            count_q, count_d;
  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic             acc;

  assign valid  = (count_q != FILL_EMPTY);
  assign full_n = (count_q != FILL_TWO);
  assign dout   = e0_q;
  assign acc    = valid && ready;

  // Next fill level and entry contents; push is never asserted while full.
  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (clear) begin
      count_d = FILL_EMPTY;
      e0_d    = {WIDTH{1'b0}};
      e1_d    = {WIDTH{1'b0}};
    end else begin
      case (count_q)
        FILL_EMPTY: begin
          if (push) begin
            e0_d    = din;
            count_d = FILL_ONE;
          end else begin
            count_d = FILL_EMPTY;
          end
        end
        FILL_ONE: begin
          if (push && acc) begin
            e0_d    = din;
            count_d = FILL_ONE;
          end else if (push) begin
            e1_d    = din;
            count_d = FILL_TWO;
          end else if (acc) begin
            count_d = FILL_EMPTY;
          end else begin
            count_d = FILL_ONE;
          end
        end
        FILL_TWO: begin
          if (acc) begin
            e0_d    = e1_q;
            count_d = FILL_ONE;
          end else begin
            count_d = FILL_TWO;
          end
        end
        default: begin
          count_d = FILL_EMPTY;
          e0_d    = {WIDTH{1'b0}};
          e1_d    = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Buffer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= FILL_EMPTY;
      e0_q    <= {WIDTH{1'b0}};
      e1_q    <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule

// File: rtl/fifo_stream_out.sv
// Pop-side FIFO adapter: registered valid/ready stream with fixed-length packet
// framing; the pop strobe depends only on registered fill and FIFO/flush flags.
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  input  logic             i_fifo_not_empty,
  output logic             o_fifo_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  input  logic             i_ready
);

  localparam int                BEAT_W    = beat_width(int'(PKT_LEN));
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic              full_n;
  logic              pop;
  logic              acc;
  logic [BEAT_W-1:0] beat_q, beat_d;

  assign pop        = i_rst_n && !i_flush && i_fifo_not_empty && full_n;
  assign o_fifo_pop = pop;
  assign acc        = o_valid && i_ready;

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_flush),
    .push  (pop),
    .din   (i_fifo_rdata),
    .full_n(full_n),
    .valid (o_valid),
    .dout  (o_data),
    .ready (i_ready)
  );

  // Beat index of the presented word; a beat offered during flush is dropped.
  always_comb begin
    beat_d = beat_q;
    if (i_flush) begin
      beat_d = {BEAT_W{1'b0}};
    end else if (acc) begin
      if (beat_q == BEAT_LAST) begin
        beat_d = {BEAT_W{1'b0}};
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end else begin
      beat_d = beat_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      beat_q <= {BEAT_W{1'b0}};
    end else begin
      beat_q <= beat_d;
    end
  end

  assign o_last = o_valid && (beat_q == BEAT_LAST);

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed + randomized bench: a queue FIFO feeds the adapter, and a queue-based
// reference (words popped but not yet accepted) predicts every output.
module tb_fifo_stream_out;

  localparam int PKT = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, ready, not_empty;
  logic [15:0] rdata;
  logic        pop4, valid4, last4;
  logic [15:0] data4;
  logic        pop1, valid1, last1;
  logic [15:0] data1;

  always #5 clk = ~clk;

  fifo_stream_out #(.WIDTH(16), .PKT_LEN(PKT)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_fifo_rdata(rdata),
    .i_fifo_not_empty(not_empty), .o_fifo_pop(pop4), .o_valid(valid4),
    .o_data(data4), .o_last(last4), .i_ready(ready));

  fifo_stream_out #(.WIDTH(16), .PKT_LEN(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_fifo_rdata(rdata),
    .i_fifo_not_empty(not_empty), .o_fifo_pop(pop1), .o_valid(valid1),
    .o_data(data1), .o_last(last1), .i_ready(ready));

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int n_pass = 0, n_fail = 0, n_total = 0;
  int beat_idx = 0, pops_seen = 0, dut_acc = 0;
  int word_ctr = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    not_empty = (fifo_q.size() != 0);
    rdata     = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(16'(word_ctr));
      word_ctr++;
    end
    drive_fifo();
  endtask

  // One clock: check at the falling edge, advance the models after the rising edge.
  task automatic tick();
    logic clr, pop_exp, v_exp, acc, pop_s, flush_s;
    @(negedge clk);
    clr     = !rst_n || flush;
    v_exp   = (exp_q.size() != 0);
    pop_exp = !clr && (fifo_q.size() != 0) && (exp_q.size() != 2);
    chk("pop", pop4, pop_exp);
    chk("pop_len1", pop1, pop_exp);
    chk("valid", valid4, v_exp);
    chk("valid_len1", valid1, v_exp);
    chk("last_len1", last1, valid1);
    if (v_exp) begin
      chk("data", data4, exp_q[0]);
      chk("data_len1", data1, exp_q[0]);
      chk("last", last4, beat_idx == PKT - 1);
    end else begin
      chk("last_idle", last4, 1'b0);
    end
    if (valid4 && ready && !clr) dut_acc++;
    pop_s   = pop4;
    flush_s = flush;
    acc     = v_exp && ready && !clr;
    if (clr) begin
      exp_q.delete();
      beat_idx = 0;
    end else begin
      if (acc) begin
        void'(exp_q.pop_front());
        beat_idx = (beat_idx + 1) % PKT;
      end
      if (pop_s && fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
    end
    if (pop_s) pops_seen++;
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (flush_s) fifo_q.delete();
    drive_fifo();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(fifo_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    int snap, start, n, target;
    rst_n = 1'b0; flush = 1'b0; ready = 1'b1;
    load(8);
    repeat (2) @(posedge clk);
    #1;
    // Reset with preloaded FIFO: outputs idle, no pops.
    repeat (2) tick();
    chk("rst_valid", valid4, 1'b0);
    chk("rst_data", data4, 16'h0000);
    chk("rst_last", last4, 1'b0);
    rst_n = 1'b1;
    dut_acc = 0;
    repeat (9) tick();
    chk("stream_8_beats", 32'(dut_acc), 32'd8);
    tick();
    chk("valid_drop", valid4, 1'b0);

    // Backpressure from an empty buffer with a full FIFO.
    ready = 1'b0;
    load(16);
    snap = pops_seen;
    repeat (5) tick();
    chk("stall_pops", 32'(pops_seen - snap), 32'd2);
    drain("bp_drain");

    // Random ready and random FIFO fill, 1000 words.
    start = dut_acc; n = 0; target = 0;
    while (dut_acc - start < 1000 && n < 20000) begin
      ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() < 16 && target < 1000 && $urandom_range(0, 1) == 1) begin
        for (int k = $urandom_range(1, 3); k > 0 && target < 1000; k--) begin
          load(1);
          target++;
        end
      end
      tick();
      n++;
    end
    chk("random_count", 32'(dut_acc - start), 32'd1000);
    drain("random_drain");

    // Flush at beat 2 with both entries full.
    load(10);
    n = 0;
    while (!(beat_idx == 2 && exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    ready = 1'b0;
    repeat (2) tick();
    chk("flush_pre_valid", valid4, 1'b1);
    flush = 1'b1; ready = 1'b1;
    snap = pops_seen;
    tick();
    flush = 1'b0;
    chk("flush_nopop", 32'(pops_seen - snap), 32'd0);
    chk("flush_valid", valid4, 1'b0);
    chk("flush_data", data4, 16'h0000);
    load(8);
    drain("flush_refill");

    // One-cycle reset mid-packet.
    load(10);
    n = 0;
    while (!(beat_idx == 1 && exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", valid4, 1'b0);
    chk("mid_rst_data", data4, 16'h0000);
    chk("mid_rst_last", last4, 1'b0);
    drain("mid_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
